// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC generator with an in-order ring buffer of outstanding and returned fetches.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bp_pc,
  input  logic        bp_pred_taken,
  input  logic        bp_pred_valid,
  input  logic [31:0] bp_pred_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        if_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = AW + 2;
  localparam logic [AW:0] P1 = 1;
  localparam logic [DW-1:0] D1 = 1;
  logic rst_q;
  logic [31:0] pc, seq_pc, tgt;
  logic [AW:0] alloc_ptr, fill_ptr, retire_ptr, in_use, outstanding;
  logic [AW-1:0] a_idx, f_idx, r_idx;
  logic [DW-1:0] discard_cnt;
  logic [31:0] e_pc [FIFO_DEPTH];
  logic [31:0] e_instr [FIFO_DEPTH];
  logic [31:0] e_tgt [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] e_pt, e_filled;
  logic pt, push, drop, fill, pop;
  assign in_use = alloc_ptr - retire_ptr;
  assign outstanding = alloc_ptr - fill_ptr;
  assign a_idx = alloc_ptr[AW-1:0];
  assign f_idx = fill_ptr[AW-1:0];
  assign r_idx = retire_ptr[AW-1:0];
  assign bp_pc = pc;
  assign imem_addr = {pc[31:2], 2'b00};
  assign seq_pc = imem_addr + 32'd4;
  assign pt = bp_pred_taken & bp_pred_valid;
  assign tgt = pt ? bp_pred_target : seq_pc;
  // Slots still owed a response (including ones to be discarded) also throttle requests.
  assign imem_req = !rst_q && in_use != (AW+1)'(FIFO_DEPTH) &&
                    (DW'(outstanding) + discard_cnt) < DW'(FIFO_DEPTH) && !redirect_en;
  assign push = imem_req & imem_gnt;
  assign drop = imem_rvalid && discard_cnt != '0;
  assign fill = imem_rvalid & !drop;
  assign if_valid = e_filled[r_idx];
  assign if_pc = e_pc[r_idx];
  assign if_instr = e_instr[r_idx];
  assign if_pred_taken = e_pt[r_idx];
  assign if_pred_target = e_tgt[r_idx];
  assign pop = if_valid & if_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q <= 1'b1;
      pc <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr <= '0;
      retire_ptr <= '0;
      discard_cnt <= '0;
      e_pt <= '0;
      e_filled <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        e_pc[i] <= '0;
        e_instr[i] <= '0;
        e_tgt[i] <= '0;
      end
    end else begin
      rst_q <= 1'b0;
      if (redirect_en) begin
        pc <= redirect_pc;
        alloc_ptr <= '0;
        fill_ptr <= '0;
        retire_ptr <= '0;
        e_filled <= '0;
        discard_cnt <= discard_cnt + DW'(outstanding) - DW'(imem_rvalid);
      end else begin
        if (push) begin
          e_pc[a_idx] <= pc;
          e_pt[a_idx] <= pt;
          e_tgt[a_idx] <= tgt;
          alloc_ptr <= alloc_ptr + P1;
          pc <= tgt;
        end
        if (drop) discard_cnt <= discard_cnt - D1;
        if (fill) begin
          e_instr[f_idx] <= imem_rdata;
          e_filled[f_idx] <= 1'b1;
          fill_ptr <= fill_ptr + P1;
        end
        if (pop) begin
          e_filled[r_idx] <= 1'b0;
          retire_ptr <= retire_ptr + P1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed stimulus with a scoreboard queue checked by an independent decode-side monitor.
module tb_fetch_pc_gen;
  localparam logic [31:0] XV = 32'hA500_0000;
  typedef struct packed {logic [31:0] pc; logic pt; logic [31:0] tgt;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] bp_pc, imem_addr, if_pc, if_instr, if_pred_target;
  logic bp_pred_taken = 1'b1, bp_pred_valid;
  logic [31:0] bp_pred_target = 32'h100;
  logic imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic redirect_en = 1'b0, if_valid, if_pred_taken, if_ready = 1'b1;
  logic btb_on = 1'b0, hold = 1'b0;
  ent_t exp_q[$];
  logic [31:0] req_log[$], mq[$];
  int pop_cyc[$];
  int tests = 0, fails = 0, cyc = 0;

  fetch_pc_gen dut (
    .clk(clk), .rst(rst), .bp_pc(bp_pc), .bp_pred_taken(bp_pred_taken),
    .bp_pred_valid(bp_pred_valid), .bp_pred_target(bp_pred_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target), .if_ready(if_ready)
  );

  // BTB hit only at 0x8 when enabled; taken bit is always 1 so the hit qualifier matters.
  assign bp_pred_valid = btb_on && bp_pc == 32'h8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_e(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    ent_t e;
    e.pc = pc;
    e.pt = pt;
    e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  task automatic grant_n(input int n);
    int cnt = 0;
    int budget = 50;
    imem_gnt = 1'b1;
    while (cnt < n && budget > 0) begin
      @(negedge clk);
      if (imem_req) cnt++;
      budget--;
      tick();
    end
    imem_gnt = 1'b0;
    chk("grant_count", cnt, n);
  endtask

  task automatic wait_drain();
    int b = 40;
    while (exp_q.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0;
    redirect_en = 1'b0;
    hold = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    req_log.delete();
    pop_cyc.delete();
    rst = 1'b0;
  endtask

  // Memory: in-order, one response per cycle at least one cycle after grant; hold stalls it.
  initial begin : mem
    logic [31:0] a;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        mq.delete();
        imem_rvalid = 1'b0;
      end else if (!hold && mq.size() > 0) begin
        a = mq.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata = a ^ XV;
      end else imem_rvalid = 1'b0;
    end
  end

  always @(negedge clk)
    if (!rst && imem_req && imem_gnt) begin
      mq.push_back(imem_addr);
      req_log.push_back(imem_addr);
    end

  always @(negedge clk) begin : mon
    ent_t e;
    if (!rst && if_valid && if_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got entry pc %h, expected none", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.pc ^ XV);
        chk("sb_pt", 32'(if_pred_taken), 32'(e.pt));
        chk("sb_tgt", if_pred_target, e.tgt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1) reset state and sequential fetch
    tick(); tick();
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pt", 32'(if_pred_taken), 0);
    chk("rst_bp_pc", bp_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    tick();
    rst = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("p1_req_after_release", 32'(imem_req), 0);
    tick();
    push_e(32'h0, 1'b0, 32'h4);
    push_e(32'h4, 1'b0, 32'h8);
    push_e(32'h8, 1'b0, 32'hC);
    push_e(32'hC, 1'b0, 32'h10);
    grant_n(4);
    wait_drain();
    chk("p1_nreq", req_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("p1_addr", req_log[i], 32'(i * 4));
    chk("p1_consec1", pop_cyc[1] - pop_cyc[0], 1);
    chk("p1_consec2", pop_cyc[2] - pop_cyc[1], 1);
    // 2) taken BTB hit at 0x8
    do_reset();
    btb_on = 1'b1;
    push_e(32'h0, 1'b0, 32'h4);
    push_e(32'h4, 1'b0, 32'h8);
    push_e(32'h8, 1'b1, 32'h100);
    push_e(32'h100, 1'b0, 32'h104);
    grant_n(4);
    wait_drain();
    chk("p2_addr3", req_log[2], 32'h8);
    chk("p2_addr4", req_log[3], 32'h100);
    btb_on = 1'b0;
    // 3) decode stalled: buffer fills to depth, then drains in order
    do_reset();
    if_ready = 1'b0;
    push_e(32'h0, 1'b0, 32'h4);
    push_e(32'h4, 1'b0, 32'h8);
    push_e(32'h8, 1'b0, 32'hC);
    push_e(32'hC, 1'b0, 32'h10);
    grant_n(4);
    imem_gnt = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("p3_req_full", 32'(imem_req), 0);
    chk("p3_nreq", req_log.size(), 4);
    chk("p3_valid", 32'(if_valid), 1);
    chk("p3_head_pc", if_pc, 32'h0);
    tick();
    imem_gnt = 1'b0;
    if_ready = 1'b1;
    wait_drain();
    // 4) redirect with three requests outstanding
    do_reset();
    hold = 1'b1;
    grant_n(3);
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("p4_req_in_redirect", 32'(imem_req), 0);
    tick();
    redirect_en = 1'b0;
    hold = 1'b0;
    chk("p4_bp_pc", bp_pc, 32'h200);
    chk("p4_valid_after", 32'(if_valid), 0);
    push_e(32'h200, 1'b0, 32'h204);
    push_e(32'h204, 1'b0, 32'h208);
    grant_n(2);
    wait_drain();
    chk("p4_nreq", req_log.size(), 5);
    chk("p4_addr_redir", req_log[3], 32'h200);
    // 5) redirect coincident with the only outstanding response
    do_reset();
    hold = 1'b1;
    grant_n(1);
    hold = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_en = 1'b0;
    push_e(32'h300, 1'b0, 32'h304);
    push_e(32'h304, 1'b0, 32'h308);
    grant_n(2);
    wait_drain();
    chk("p5_nreq", req_log.size(), 3);
    // 6) asynchronous reset mid-stream
    do_reset();
    if_ready = 1'b0;
    grant_n(3);
    repeat (3) tick();
    @(negedge clk);
    chk("p6_valid_before", 32'(if_valid), 1);
    chk("p6_bp_pc_before", bp_pc, 32'hC);
    #1 rst = 1'b1;
    #1;
    chk("p6_valid_async", 32'(if_valid), 0);
    chk("p6_req_async", 32'(imem_req), 0);
    chk("p6_bp_pc_async", bp_pc, 32'h0);
    chk("p6_pt_async", 32'(if_pred_taken), 0);
    do_reset();
    if_ready = 1'b1;
    push_e(32'h0, 1'b0, 32'h4);
    grant_n(1);
    wait_drain();
    chk("p6_nreq", req_log.size(), 1);
    chk("p6_first_addr", req_log[0], 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
